// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and the latched request.
package dmem_arbiter_pkg;

    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_MASK_W = DMEM_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP
    } dmem_arb_state_e;

    // Sized from the package widths; the arbiter parameters default to the same values.
    typedef struct packed {
        logic                   wen;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] data;
        logic [DMEM_MASK_W-1:0] mask;
    } dmem_req_s;

endpackage

// File: rtl/dmem_arbiter_rr_picker.sv
// Combinational round-robin select: first set request at or after ptr, scanning cyclically upward.
module rr_picker #(
    parameter int num_cores_p = 2
) (
    input  logic [num_cores_p-1:0]         req,
    input  logic [$clog2(num_cores_p)-1:0] ptr,
    output logic [num_cores_p-1:0]         gnt,
    output logic [$clog2(num_cores_p)-1:0] idx,
    output logic                           any
);

    localparam int pw_lp = $clog2(num_cores_p);

    always_comb begin
        int c;
        c   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int off = 0; off < num_cores_p; off++) begin
            c = (int'(ptr) + off) % num_cores_p;
            if (!any && req[c]) begin
                any    = 1'b1;
                gnt[c] = 1'b1;
                idx    = c[pw_lp-1:0];
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between num_cores_p cores.
// Optional request locking is compiled in with `define DMEM_ARB_LOCK_EN.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int num_cores_p  = 2,
    parameter int addr_width_p = DMEM_ADDR_W,
    parameter int data_width_p = DMEM_DATA_W,
    parameter int mask_width_p = DMEM_MASK_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [num_cores_p-1:0]            req_valid_i,
    input  logic [num_cores_p-1:0]            req_wen_i,
    input  logic [num_cores_p-1:0]            req_lock_i,
    input  logic [num_cores_p*addr_width_p-1:0] req_addr_i,
    input  logic [num_cores_p*data_width_p-1:0] req_data_i,
    input  logic [num_cores_p*mask_width_p-1:0] req_mask_i,
    output logic [num_cores_p-1:0]            grant_o,
    output logic [num_cores_p-1:0]            resp_valid_o,
    output logic [data_width_p-1:0]           resp_data_o,
    output logic                              mem_valid_o,
    output logic                              mem_wen_o,
    output logic [addr_width_p-1:0]           mem_addr_o,
    output logic [data_width_p-1:0]           mem_data_o,
    output logic [mask_width_p-1:0]           mem_mask_o,
    input  logic                              mem_ready_i,
    input  logic                              mem_resp_valid_i,
    input  logic [data_width_p-1:0]           mem_resp_data_i,
    output logic                              err_o
);

    localparam int pw_lp = $clog2(num_cores_p);

    dmem_arb_state_e         state;
    logic [pw_lp-1:0]        rr_ptr;
    logic [pw_lp-1:0]        owner;
    dmem_req_s               lat;
    dmem_req_s               sel;
    logic [num_cores_p-1:0]  cand;
    logic [num_cores_p-1:0]  pick_gnt;
    logic [pw_lp-1:0]        pick_idx;
    logic                    pick_any;
    logic [pw_lp-1:0]        next_ptr;

`ifdef DMEM_ARB_LOCK_EN
    logic locked;

    // While locked only the owner may win; everyone else is starved.
    always_comb begin
        cand = req_valid_i;
        if (locked) begin
            cand        = '0;
            cand[owner] = req_valid_i[owner];
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^req_lock_i;
    assign cand        = req_valid_i;
`endif

    rr_picker #(.num_cores_p(num_cores_p)) u_pick (
        .req (cand),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        sel      = '0;
        sel.wen  = req_wen_i[pick_idx];
        sel.addr[addr_width_p-1:0] = req_addr_i[int'(pick_idx)*addr_width_p +: addr_width_p];
        sel.data[data_width_p-1:0] = req_data_i[int'(pick_idx)*data_width_p +: data_width_p];
        sel.mask[mask_width_p-1:0] = req_mask_i[int'(pick_idx)*mask_width_p +: mask_width_p];
    end

    assign next_ptr = (int'(pick_idx) == num_cores_p - 1) ? '0 : pick_idx + 1'b1;

    // Grant is issued in the same cycle the request is seen while idle.
    assign grant_o = (state == IDLE && !reset) ? pick_gnt : '0;

    assign mem_wen_o  = lat.wen;
    assign mem_addr_o = lat.addr[addr_width_p-1:0];
    assign mem_data_o = lat.data[data_width_p-1:0];
    assign mem_mask_o = lat.mask[mask_width_p-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            lat          <= '0;
            mem_valid_o  <= 1'b0;
            resp_valid_o <= '0;
            resp_data_o  <= '0;
            err_o        <= 1'b0;
`ifdef DMEM_ARB_LOCK_EN
            locked       <= 1'b0;
`endif
        end else begin
            resp_valid_o <= '0;
            if (mem_resp_valid_i && state != WAIT_RESP)
                err_o <= 1'b1;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        lat         <= sel;
                        owner       <= pick_idx;
                        mem_valid_o <= 1'b1;
                        state       <= ISSUE;
`ifdef DMEM_ARB_LOCK_EN
                        if (req_lock_i[pick_idx]) begin
                            locked <= 1'b1;
                        end else begin
                            locked <= 1'b0;
                            rr_ptr <= next_ptr;
                        end
`else
                        rr_ptr <= next_ptr;
`endif
                    end
                end
                ISSUE: begin
                    if (mem_ready_i) begin
                        mem_valid_o <= 1'b0;
                        if (lat.wen) begin
                            resp_valid_o[owner] <= 1'b1;
                            state               <= IDLE;
                        end else begin
                            state <= WAIT_RESP;
                        end
                    end
                end
                WAIT_RESP: begin
                    if (mem_resp_valid_i) begin
                        resp_data_o         <= mem_resp_data_i;
                        resp_valid_o[owner] <= 1'b1;
                        state               <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: request drivers, memory responder and reference ordering model.
module tb_dmem_arbiter;

    localparam int NC = 2;
`ifdef DMEM_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    typedef struct {
        logic        wen;
        logic        lock;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } treq_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [NC-1:0]     req_valid_i, req_wen_i, req_lock_i;
    logic [NC*32-1:0]  req_addr_i, req_data_i;
    logic [NC*4-1:0]   req_mask_i;
    logic [NC-1:0]     grant_o, resp_valid_o;
    logic [31:0]       resp_data_o;
    logic              mem_valid_o, mem_wen_o;
    logic [31:0]       mem_addr_o, mem_data_o;
    logic [3:0]        mem_mask_o;
    logic              mem_ready_i, mem_resp_valid_i;
    logic [31:0]       mem_resp_data_i;
    logic              err_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    treq_t         reqs [NC][$];
    logic [NC-1:0] gnt_q [$];
    logic [NC-1:0] rsp_q [$];
    logic [31:0]   rspd_q [$];
    int            gntc_q [$];
    int            rspc_q [$];
    logic [NC-1:0] last_gnt = '0;
    logic [31:0]   env_mem [logic [31:0]];
    logic [31:0]   ref_mem [logic [31:0]];
    int stall_lo = 0, stall_hi = 0, lat_lo = 1, lat_hi = 1;
    int spur_req = 0;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid_i), .req_wen_i(req_wen_i), .req_lock_i(req_lock_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_mask_i(req_mask_i),
        .grant_o(grant_o), .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o),
        .mem_valid_o(mem_valid_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_mask_o(mem_mask_o), .mem_ready_i(mem_ready_i),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i), .err_o(err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h3C5A_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] env_rd(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [NC-1:0] onehot(input int c);
        logic [NC-1:0] v;
        v = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    function automatic treq_t mk(input logic w, input logic l, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] m);
        treq_t t;
        t.wen = w; t.lock = l; t.addr = a; t.data = d; t.mask = m;
        return t;
    endfunction

    // Monitor: samples away from the clock edge and logs grants and responses.
    always begin
        @(negedge clk);
        #3;
        last_gnt = grant_o;
        if (!reset) begin
            if (grant_o != '0) begin gnt_q.push_back(grant_o); gntc_q.push_back(cyc); end
            if (resp_valid_o != '0) begin
                rsp_q.push_back(resp_valid_o); rspd_q.push_back(resp_data_o); rspc_q.push_back(cyc);
            end
        end
    end

    // Requesters: each core holds its current request until it has been granted.
    initial begin
        int    ptr [NC];
        bit    pres [NC];
        treq_t t;
        req_valid_i = '0; req_wen_i = '0; req_lock_i = '0;
        req_addr_i = '0; req_data_i = '0; req_mask_i = '0;
        for (int i = 0; i < NC; i++) begin ptr[i] = 0; pres[i] = 1'b0; end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NC; i++) begin
                if (pres[i] && last_gnt[i]) begin ptr[i]++; pres[i] = 1'b0; end
                if (ptr[i] < reqs[i].size()) begin
                    t = reqs[i][ptr[i]];
                    pres[i] = 1'b1;
                    req_valid_i[i] = 1'b1;
                    req_wen_i[i] = t.wen;
                    req_lock_i[i] = t.lock;
                    req_addr_i[i*32 +: 32] = t.addr;
                    req_data_i[i*32 +: 32] = t.data;
                    req_mask_i[i*4 +: 4] = t.mask;
                end else begin
                    req_valid_i[i] = 1'b0;
                    req_lock_i[i] = 1'b0;
                end
            end
        end
    end

    // Memory responder with configurable accept stall and read latency.
    initial begin
        bit pend, active;
        int pcnt, scnt, cur, spur_done;
        logic [31:0] pdat;
        pend = 0; active = 0; pcnt = 0; scnt = 0; cur = 0; spur_done = 0; pdat = '0;
        mem_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
        forever begin
            @(negedge clk);
            mem_ready_i = 1'b0;
            mem_resp_valid_i = 1'b0;
            if (reset) begin
                pend = 0; active = 0; scnt = 0;
            end else if (pend) begin
                if (pcnt == 0) begin mem_resp_valid_i = 1'b1; mem_resp_data_i = pdat; pend = 0; end
                else pcnt--;
            end else if (spur_done < spur_req) begin
                mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'h0BAD_F00D; spur_done++;
            end else if (mem_valid_o) begin
                if (!active) begin active = 1; scnt = 0; cur = $urandom_range(stall_hi, stall_lo); end
                if (scnt < cur) scnt++;
                else begin
                    mem_ready_i = 1'b1; active = 0;
                    if (mem_wen_o) env_mem[mem_addr_o] = merge(env_rd(mem_addr_o), mem_data_o, mem_mask_o);
                    else begin pend = 1; pcnt = $urandom_range(lat_hi, lat_lo) - 1; pdat = env_rd(mem_addr_o); end
                end
            end
        end
    end

    task automatic smp();
        @(negedge clk);
        #4;
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            smp();
            if (rsp_q.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        bit ok;
        reqs[0].push_back(mk(0, 0, 32'h100, 0, 4'hF));
        for (int k = 0; k < 2; k++) begin
            smp();
            checks++;
            if ({grant_o, resp_valid_o, resp_data_o, mem_valid_o, mem_wen_o, mem_addr_o,
                 mem_data_o, mem_mask_o, err_o} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: grant=%b resp=%b mem_valid=%b addr=%h err=%b, all required 0",
                         grant_o, resp_valid_o, mem_valid_o, mem_addr_o, err_o);
            end
        end
        @(negedge clk); reset = 1'b0;
        #4;
        checks++;
        if (grant_o !== 2'b01) begin errors++; $display("FAIL reset_first_grant: got %b want 01", grant_o); end
        wait_rsp(1, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL reset_rsp_timeout: got %0d rsps want 1", rsp_q.size()); end
        else begin
            checks++;
            if (rspd_q[0] !== dflt(32'h100)) begin
                errors++; $display("FAIL reset_rd_data: got %h want %h", rspd_q[0], dflt(32'h100));
            end
            checks++;
            if (rspc_q[0] - gntc_q[0] !== 3) begin
                errors++; $display("FAIL min_read_latency: got %0d want 3", rspc_q[0] - gntc_q[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int gb, rb;
        bit seen;
        do_reset();
        stall_lo = 20; stall_hi = 20;
        gb = gnt_q.size(); rb = rsp_q.size();
        reqs[0].push_back(mk(0, 0, 32'h200, 0, 4'hF));
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin smp(); seen = (gnt_q.size() > gb); end
        checks++;
        if (!seen) begin errors++; $display("FAIL midreset_grant: no grant seen, want one"); end
        smp();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        stall_lo = 0; stall_hi = 0;
        repeat (10) smp();
        checks++;
        if (gnt_q.size() !== gb + 1 || rsp_q.size() !== rb) begin
            errors++;
            $display("FAIL midreset_abandon: grants=%0d rsps=%0d want %0d and %0d",
                     gnt_q.size() - gb, rsp_q.size() - rb, 1, 0);
        end
        checks++;
        if (mem_valid_o !== 1'b0 || err_o !== 1'b0) begin
            errors++; $display("FAIL midreset_idle: mem_valid=%b err=%b want 0 0", mem_valid_o, err_o);
        end
    endtask

    task automatic test_simul();
        int gb, rb;
        bit ok;
        do_reset();
        lat_lo = 1; lat_hi = 1;
        gb = gnt_q.size(); rb = rsp_q.size();
        reqs[0].push_back(mk(0, 0, 32'h10, 0, 4'hF));
        reqs[1].push_back(mk(0, 0, 32'h20, 0, 4'hF));
        wait_rsp(rb + 2, 30, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL simul_timeout: got %0d rsps want 2", rsp_q.size() - rb); end
        else begin
            checks++;
            if (gnt_q[gb] !== 2'b01 || gnt_q[gb+1] !== 2'b10) begin
                errors++; $display("FAIL simul_grants: got %b,%b want 01,10", gnt_q[gb], gnt_q[gb+1]);
            end
            checks++;
            if (rsp_q[rb] !== 2'b01 || rspd_q[rb] !== dflt(32'h10)) begin
                errors++; $display("FAIL simul_rsp0: got %b/%h want 01/%h", rsp_q[rb], rspd_q[rb], dflt(32'h10));
            end
            checks++;
            if (rsp_q[rb+1] !== 2'b10 || rspd_q[rb+1] !== dflt(32'h20)) begin
                errors++; $display("FAIL simul_rsp1: got %b/%h want 10/%h", rsp_q[rb+1], rspd_q[rb+1], dflt(32'h20));
            end
            checks++;
            if (gntc_q[gb+1] - rspc_q[rb] !== 0) begin
                errors++; $display("FAIL simul_overlap: second grant %0d cycles after first rsp, want 0",
                                   gntc_q[gb+1] - rspc_q[rb]);
            end
        end
    endtask

    task automatic test_write_ack();
        int rb;
        bit seen, ok;
        do_reset();
        stall_lo = 3; stall_hi = 3;
        reqs[1].push_back(mk(1, 0, 32'h40, 32'hDEADBEEF, 4'hF));
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin smp(); seen = (grant_o === 2'b10); end
        checks++;
        if (!seen) begin errors++; $display("FAIL wr_grant: no grant 10 seen"); end
        for (int k = 0; k < 4; k++) begin
            smp();
            checks++;
            if ({mem_valid_o, mem_wen_o, mem_addr_o, mem_data_o, mem_mask_o} !==
                {1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF} || mem_ready_i !== (k == 3)) begin
                errors++;
                $display("FAIL wr_stable[%0d]: v=%b w=%b a=%h d=%h m=%h rdy=%b want 1 1 40 deadbeef f %b",
                         k, mem_valid_o, mem_wen_o, mem_addr_o, mem_data_o, mem_mask_o, mem_ready_i, k == 3);
            end
        end
        smp();
        checks++;
        if (resp_valid_o !== 2'b10) begin errors++; $display("FAIL wr_ack: got %b want 10", resp_valid_o); end
        stall_lo = 0; stall_hi = 0;
        rb = rsp_q.size();
        reqs[0].push_back(mk(0, 0, 32'h40, 0, 4'hF));
        wait_rsp(rb + 1, 30, ok);
        checks++;
        if (!ok || rspd_q[rb] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_readback: ok=%b got %h want deadbeef", ok, ok ? rspd_q[rb] : 32'h0);
        end
    endtask

    task automatic test_fairness();
        int gb, rb;
        bit ok;
        logic [31:0] a [NC][4];
        do_reset();
        stall_lo = 0; stall_hi = 1; lat_lo = 1; lat_hi = 3;
        gb = gnt_q.size(); rb = rsp_q.size();
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < NC; i++) begin
                a[i][j] = 32'h1000 + 32'($urandom_range(255, 0)) * 4;
                reqs[i].push_back(mk(0, 0, a[i][j], 0, 4'hF));
            end
        wait_rsp(rb + 8, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL fair_timeout: got %0d rsps want 8", rsp_q.size() - rb); end
        else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (gnt_q[gb+k] !== onehot(k % 2) || rsp_q[rb+k] !== onehot(k % 2) ||
                    rspd_q[rb+k] !== dflt(a[k%2][k/2])) begin
                    errors++;
                    $display("FAIL fair[%0d]: grant=%b rsp=%b data=%h want %b %b %h", k, gnt_q[gb+k],
                             rsp_q[rb+k], rspd_q[rb+k], onehot(k % 2), onehot(k % 2), dflt(a[k%2][k/2]));
                end
            end
        end
    endtask

    task automatic test_err();
        int rb;
        bit ok;
        do_reset();
        stall_lo = 0; stall_hi = 0; lat_lo = 1; lat_hi = 1;
        rb = rsp_q.size();
        smp();
        checks++;
        if (err_o !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", err_o); end
        spur_req++;
        repeat (4) smp();
        checks++;
        if (err_o !== 1'b1 || rsp_q.size() !== rb) begin
            errors++; $display("FAIL err_set: err=%b rsps=%0d want 1 0", err_o, rsp_q.size() - rb);
        end
        reqs[1].push_back(mk(0, 0, 32'h80, 0, 4'hF));
        wait_rsp(rb + 1, 30, ok);
        repeat (3) smp();
        checks++;
        if (!ok || err_o !== 1'b1 || rsp_q.size() !== rb + 1) begin
            errors++; $display("FAIL err_sticky: ok=%b err=%b rsps=%0d want 1 1 1", ok, err_o, rsp_q.size() - rb);
        end
    endtask

    task automatic test_lock();
        int gb, rb, p, own, total;
        bit ok, lk;
        treq_t lst [NC][$];
        int nxt [NC];
        int exp_c [$];
        do_reset();
        stall_lo = 0; stall_hi = 1; lat_lo = 1; lat_hi = 2;
        for (int j = 0; j < 4; j++) lst[0].push_back(mk(0, j < 3, 32'h2000 + 32'(j) * 4, 0, 4'hF));
        for (int j = 0; j < 2; j++) lst[1].push_back(mk(0, 0, 32'h2100 + 32'(j) * 4, 0, 4'hF));
        total = lst[0].size() + lst[1].size();
        p = 0; lk = 0; own = 0;
        for (int i = 0; i < NC; i++) nxt[i] = 0;
        for (int k = 0; k < total; k++) begin
            int c;
            c = own;
            if (!lk)
                for (int off = NC - 1; off >= 0; off--)
                    if (nxt[(p + off) % NC] < lst[(p + off) % NC].size()) c = (p + off) % NC;
            exp_c.push_back(c);
            if (LOCK_EN && lst[c][nxt[c]].lock) begin lk = 1; own = c; end
            else begin lk = 0; p = (c + 1) % NC; end
            nxt[c]++;
        end
        gb = gnt_q.size(); rb = rsp_q.size();
        for (int i = 0; i < NC; i++) foreach (lst[i][j]) reqs[i].push_back(lst[i][j]);
        wait_rsp(rb + total, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL lock_timeout: got %0d rsps want %0d", rsp_q.size() - rb, total); end
        else
            for (int k = 0; k < total; k++) begin
                checks++;
                if (gnt_q[gb+k] !== onehot(exp_c[k])) begin
                    errors++; $display("FAIL lock_order[%0d]: got %b want %b", k, gnt_q[gb+k], onehot(exp_c[k]));
                end
            end
    endtask

    task automatic test_random();
        int p, own;
        bit lk, ok;
        logic [31:0] want;
        do_reset();
        p = 0; lk = 0; own = 0;
        for (int r = 0; r < 3; r++) begin
            treq_t lst [NC][$];
            int nxt [NC];
            int exp_c [$];
            treq_t exp_t [$];
            int gb, rb, total;
            stall_lo = 0; stall_hi = 2; lat_lo = 1; lat_hi = 3;
            total = 0;
            for (int i = 0; i < NC; i++) begin
                int len;
                len = $urandom_range(5, 1);
                for (int j = 0; j < len; j++)
                    lst[i].push_back(mk(1'($urandom_range(1, 0)), (j < len - 1) ? 1'($urandom_range(1, 0)) : 1'b0,
                                        32'h300 + 32'($urandom_range(3, 0)) * 4, $urandom,
                                        4'($urandom_range(15, 1))));
                total += len;
                nxt[i] = 0;
            end
            for (int k = 0; k < total; k++) begin
                int c;
                c = own;
                if (!lk)
                    for (int off = NC - 1; off >= 0; off--)
                        if (nxt[(p + off) % NC] < lst[(p + off) % NC].size()) c = (p + off) % NC;
                exp_c.push_back(c);
                exp_t.push_back(lst[c][nxt[c]]);
                if (LOCK_EN && lst[c][nxt[c]].lock) begin lk = 1; own = c; end
                else begin lk = 0; p = (c + 1) % NC; end
                nxt[c]++;
            end
            gb = gnt_q.size(); rb = rsp_q.size();
            for (int i = 0; i < NC; i++) foreach (lst[i][j]) reqs[i].push_back(lst[i][j]);
            wait_rsp(rb + total, 400, ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL rand_timeout[%0d]: got %0d rsps want %0d", r, rsp_q.size() - rb, total);
            end else
                for (int k = 0; k < total; k++) begin
                    want = exp_t[k].wen ? 32'h0 : ref_rd(exp_t[k].addr);
                    if (exp_t[k].wen) ref_mem[exp_t[k].addr] = merge(ref_rd(exp_t[k].addr), exp_t[k].data, exp_t[k].mask);
                    checks++;
                    if (gnt_q[gb+k] !== onehot(exp_c[k]) || rsp_q[rb+k] !== onehot(exp_c[k]) ||
                        (!exp_t[k].wen && rspd_q[rb+k] !== want)) begin
                        errors++;
                        $display("FAIL rand[%0d.%0d]: grant=%b rsp=%b data=%h want %b %b %h (wen=%b)", r, k,
                                 gnt_q[gb+k], rsp_q[rb+k], rspd_q[rb+k], onehot(exp_c[k]), onehot(exp_c[k]),
                                 want, exp_t[k].wen);
                    end
                end
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_reset_mid();
        test_simul();
        test_write_ack();
        test_fairness();
        test_err();
        test_lock();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
